// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with flush (bubble) and stall (hold).
// Optional flush-event counter enabled by macro IDEX_BUBBLE_COUNT_EN. Rev 1.0
`default_nettype none

module id_ex_pipe_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        FlushE,
  input  logic        StallE,
  input  logic        ValidD,
  input  logic        RegWriteD,
  input  logic        MemtoRegD,
  input  logic        MemWriteD,
  input  logic [2:0]  ALUControlD,
  input  logic        ALUSrcD,
  input  logic        RegDstD,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RdD,
  input  logic [31:0] SignImmD,
  output logic        ValidE,
  output logic        RegWriteE,
  output logic        MemtoRegE,
  output logic        MemWriteE,
  output logic [2:0]  ALUControlE,
  output logic        ALUSrcE,
  output logic        RegDstE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [4:0]  RsE,
  output logic [4:0]  RtE,
  output logic [4:0]  RdE,
  output logic [31:0] SignImmE,
  output logic [15:0] BubbleCountE
);

  // A flush zeroes everything, so the bubble writes $0 with RegWrite/MemWrite low.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      ValidE      <= 1'b0;
      RegWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUControlE <= 3'b000;
      ALUSrcE     <= 1'b0;
      RegDstE     <= 1'b0;
      RD1E        <= 32'h0000_0000;
      RD2E        <= 32'h0000_0000;
      RsE         <= 5'd0;
      RtE         <= 5'd0;
      RdE         <= 5'd0;
      SignImmE    <= 32'h0000_0000;
    end else if (!StallE) begin
      ValidE      <= ValidD;
      RegWriteE   <= RegWriteD;
      MemtoRegE   <= MemtoRegD;
      MemWriteE   <= MemWriteD;
      ALUControlE <= ALUControlD;
      ALUSrcE     <= ALUSrcD;
      RegDstE     <= RegDstD;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      RsE         <= RsD;
      RtE         <= RtD;
      RdE         <= RdD;
      SignImmE    <= SignImmD;
    end
  end

`ifdef IDEX_BUBBLE_COUNT_EN
  logic [15:0] bubble_cnt;

  // Saturating count of flush edges; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= 16'h0000;
    end else if (FlushE && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

  assign BubbleCountE = bubble_cnt;
`else
  assign BubbleCountE = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: randomized self-checking bench for id_ex_pipe_reg.
`default_nettype none

module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, FlushE, StallE;
  logic        ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, SignImmD;
  logic [4:0]  RsD, RtD, RdD;
  logic        ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, SignImmE;
  logic [4:0]  RsE, RtE, RdE;
  logic [15:0] BubbleCountE;

  int compared = 0;
  int mismatched = 0;

  // Reference model: the E-stage instruction as one bundle, plus a flush tally.
  logic [119:0] exp_e;
  int           exp_cnt;

  wire [119:0] obs_e = {ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUControlE, ALUSrcE,
                        RegDstE, RD1E, RD2E, RsE, RtE, RdE, SignImmE};
  wire [119:0] d_in  = {ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUControlD, ALUSrcD,
                        RegDstD, RD1D, RD2D, RsD, RtD, RdD, SignImmD};

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .reset(reset), .FlushE(FlushE), .StallE(StallE),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
    .RD1D(RD1D), .RD2D(RD2D), .RsD(RsD), .RtD(RtD), .RdD(RdD), .SignImmD(SignImmD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
    .RD1E(RD1E), .RD2E(RD2E), .RsE(RsE), .RtE(RtE), .RdE(RdE), .SignImmE(SignImmE),
    .BubbleCountE(BubbleCountE)
  );

  function automatic logic [15:0] exp_count();
`ifdef IDEX_BUBBLE_COUNT_EN
    return (exp_cnt > 65535) ? 16'hFFFF : 16'(exp_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic rand_d();
    {ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD} = 6'($urandom);
    ALUControlD = 3'($urandom);
    RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom;
    RsD = 5'($urandom); RtD = 5'($urandom); RdD = 5'($urandom);
  endtask

  // Advance one edge and apply the behavioural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      exp_e = '0; exp_cnt = 0;
    end else if (FlushE) begin
      exp_e = '0; exp_cnt = exp_cnt + 1;
    end else if (!StallE) begin
      exp_e = d_in;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; FlushE = 1'b0; StallE = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_d();
      tick();
      compared++;
      if (obs_e !== 120'd0) begin
        mismatched++; $display("FAIL reset_outputs obs=%h exp=0", obs_e);
      end
      compared++;
      if (BubbleCountE !== 16'h0000) begin
        mismatched++; $display("FAIL reset_count obs=%h exp=0000", BubbleCountE);
      end
    end
    reset = 1'b0;
  endtask

  task automatic load_known();
    rand_d();
    ValidD = 1'b1; RegWriteD = 1'b1; RegDstD = 1'b1; RtD = 5'd9; RdD = 5'd17;
    RD1D = 32'hDEADBEEF; ALUControlD = 3'b010;
    tick();
  endtask

  task automatic test_normal_load();
    FlushE = 1'b0; StallE = 1'b0;
    load_known();
    compared++;
    if ({RegWriteE, RegDstE, RtE, RdE, RD1E, ALUControlE} !==
        {1'b1, 1'b1, 5'd9, 5'd17, 32'hDEADBEEF, 3'b010}) begin
      mismatched++;
      $display("FAIL normal_load obs=%b %b %0d %0d %h %b exp=1 1 9 17 deadbeef 010",
               RegWriteE, RegDstE, RtE, RdE, RD1E, ALUControlE);
    end
    compared++;
    if (obs_e !== exp_e) begin
      mismatched++; $display("FAIL normal_load_all obs=%h exp=%h", obs_e, exp_e);
    end
  endtask

  task automatic test_stall();
    load_known();
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_d(); RD1D = 32'h12345678;
      tick();
      compared++;
      if (RD1E !== 32'hDEADBEEF || obs_e !== exp_e) begin
        mismatched++; $display("FAIL stall_hold%0d obs=%h exp=%h", i, obs_e, exp_e);
      end
    end
    StallE = 1'b0;
    tick();
    compared++;
    if (RD1E !== 32'h12345678 || obs_e !== exp_e) begin
      mismatched++; $display("FAIL stall_release obs=%h exp=%h", obs_e, exp_e);
    end
  endtask

  task automatic test_flush_with_stall();
    load_known();
    FlushE = 1'b1; StallE = 1'b1;
    rand_d();
    tick();
    FlushE = 1'b0; StallE = 1'b0;
    compared++;
    if (obs_e !== 120'd0 || ValidE !== 1'b0) begin
      mismatched++; $display("FAIL flush_with_stall obs=%h exp=0", obs_e);
    end
    compared++;
    if (BubbleCountE !== exp_count()) begin
      mismatched++; $display("FAIL flush_count obs=%h exp=%h", BubbleCountE, exp_count());
    end
  endtask

  task automatic test_reset_mid_stall();
    load_known();
    StallE = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++;
    if (obs_e !== 120'd0 || BubbleCountE !== 16'h0000) begin
      mismatched++; $display("FAIL reset_mid_stall obs=%h cnt=%h exp=0", obs_e, BubbleCountE);
    end
    StallE = 1'b0;
  endtask

  task automatic test_counter();
    reset = 1'b1; tick(); reset = 1'b0;
    FlushE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_d(); StallE = 1'($urandom);
      tick();
    end
    compared++;
    if (BubbleCountE !== exp_count()) begin
      mismatched++; $display("FAIL count_five obs=%h exp=%h", BubbleCountE, exp_count());
    end
`ifdef IDEX_BUBBLE_COUNT_EN
    for (int i = 0; i < 65535; i++) tick();
    compared++;
    if (BubbleCountE !== 16'hFFFF) begin
      mismatched++; $display("FAIL count_saturate obs=%h exp=ffff", BubbleCountE);
    end
`endif
    tick();
    compared++;
    if (BubbleCountE !== exp_count()) begin
      mismatched++; $display("FAIL count_hold obs=%h exp=%h", BubbleCountE, exp_count());
    end
    FlushE = 1'b0; StallE = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_d();
      reset  = ($urandom_range(0, 29) == 0);
      FlushE = ($urandom_range(0, 4) == 0);
      StallE = ($urandom_range(0, 3) == 0);
      tick();
      compared++;
      if (obs_e !== exp_e || BubbleCountE !== exp_count()) begin
        mismatched++;
        $display("FAIL random%0d obs=%h cnt=%h exp=%h cnt=%h", i, obs_e, BubbleCountE,
                 exp_e, exp_count());
      end
    end
    reset = 1'b0; FlushE = 1'b0; StallE = 1'b0;
  endtask

  task automatic test_back_to_back_flush();
    load_known();
    FlushE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_d();
      tick();
      compared++;
      if (obs_e !== 120'd0 || BubbleCountE !== exp_count()) begin
        mismatched++; $display("FAIL flush_b2b%0d obs=%h cnt=%h", i, obs_e, BubbleCountE);
      end
    end
    FlushE = 1'b0;
  endtask

  initial begin
    exp_e = '0; exp_cnt = 0;
    reset = 1'b1; FlushE = 1'b0; StallE = 1'b0;
    rand_d();
    test_reset();
    test_normal_load();
    test_stall();
    test_flush_with_stall();
    test_back_to_back_flush();
    test_reset_mid_stall();
    test_random();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
